rename_commit_queue: RTL and testbench

- In-order retirement queue downstream of the rename register file.
- Records each newly allocated physical name in program order and tracks when its producing write completes.
- Retires completed entries strictly in order, one per cycle, and emits a free request (name + enable) that drives the rename file's NAME_F/FE port.
- Flush drops all in-flight entries without freeing them.

---
 rtl/rename_pkg.sv | 23 ++
 rtl/rcq_ptr.sv | 30 +++
 rtl/rename_commit_queue.sv | 160 ++++++++++++++++
 tb/tb_rename_commit_queue.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// rename_pkg: types and constants shared between the rename register file
// and the in-order commit queue that hands names back to it.
//   NAME_WIDTH    - width of a physical register name
//   RCQ_DEPTH     - commit queue entries (power of two)
//   RCQ_TAG_WIDTH - width of a commit queue entry tag
//   name_t, tag_t - name and tag types at the default sizes
//   rcq_entry_t   - one commit queue entry {name, valid, done}
package rename_pkg;

    localparam int NAME_WIDTH    = 6;
    localparam int RCQ_DEPTH     = 16;
    localparam int RCQ_TAG_WIDTH = $clog2(RCQ_DEPTH);

    typedef logic [NAME_WIDTH-1:0]    name_t;
    typedef logic [RCQ_TAG_WIDTH-1:0] tag_t;

    typedef struct packed {
        name_t name;
        logic  valid;
        logic  done;
    } rcq_entry_t;

endpackage

// File: rtl/rcq_ptr.sv
// rcq_ptr: wrapping queue pointer. The range is a power of two, so the
// natural binary rollover of the register is the modulo wrap.
//   clk   - clock
//   srst  - synchronous active-high reset (pointer to 0)
//   clr   - synchronous clear (pointer to 0), priority over inc
//   inc   - advance by one
//   value - current pointer
module rcq_ptr #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             inc,
    output logic [width-1:0] value
);

    logic [width-1:0] value_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            value_reg <= '0;
        end else if (inc) begin
            value_reg <= value_reg + width'(1);
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/rename_commit_queue.sv
// rename_commit_queue: in-order retirement queue behind the rename file.
// Newly allocated physical names are recorded in program order; each entry
// is marked done when its producing write completes, and done entries retire
// strictly from the head, one per cycle, as a registered free request
// (FREE_E/FREE_NAME) for the rename file. FLUSH drops everything in flight
// without freeing it.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   ENQ_E, ENQ_NAME     enqueue request and name (accepted when ENQ_READY)
//   ENQ_READY, ENQ_TAG  not-full, tag the next enqueued entry receives
//   DONE_E, DONE_TAG    mark entry DONE_TAG complete
//   FLUSH               discard all entries
//   FREE_E, FREE_NAME   registered free pulse and name
//   COUNT, EMPTY        occupancy
// Optional build macro RENAME_COMMIT_STATS_EN adds RETIRE_COUNT and
// STALL_COUNT (32-bit, wrapping, cleared only by RST).
module rename_commit_queue
    import rename_pkg::*;
#(
    parameter int name_width = NAME_WIDTH,
    parameter int depth      = RCQ_DEPTH,
    parameter int tag_width  = $clog2(depth)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENQ_E,
    input  logic [name_width-1:0] ENQ_NAME,
    output logic                  ENQ_READY,
    output logic [tag_width-1:0]  ENQ_TAG,
    input  logic                  DONE_E,
    input  logic [tag_width-1:0]  DONE_TAG,
    input  logic                  FLUSH,
    output logic                  FREE_E,
    output logic [name_width-1:0] FREE_NAME,
    output logic [tag_width:0]    COUNT,
    output logic                  EMPTY
`ifdef RENAME_COMMIT_STATS_EN
    ,
    output logic [31:0]           RETIRE_COUNT,
    output logic [31:0]           STALL_COUNT
`endif
);

    localparam logic [tag_width:0] full_count = (tag_width+1)'(depth);

    logic [tag_width-1:0]  head;
    logic [tag_width-1:0]  tail;
    logic [tag_width:0]    count_reg;
    logic [depth-1:0]      valid_reg;
    logic [depth-1:0]      done_reg;
    logic [name_width-1:0] name_mem [depth];
    logic                  free_e_reg;
    logic [name_width-1:0] free_name_reg;

    logic enq;
    logic ret;
    logic done_hit;

    // Ready depends only on the current count, so a full queue that retires
    // this cycle still rejects a same-cycle enqueue.
    assign ENQ_READY = (count_reg != full_count);
    assign enq       = ENQ_E && ENQ_READY && !FLUSH;
    assign ret       = (count_reg != '0) && valid_reg[head] && done_reg[head] && !FLUSH;
    // Uses the pre-edge valid bit: a completion aimed at the slot being
    // enqueued this same cycle is dropped.
    assign done_hit  = DONE_E && valid_reg[DONE_TAG] && !FLUSH;

    rcq_ptr #(.width(tag_width)) head_ptr (
        .clk   (CLK),
        .srst  (RST),
        .clr   (FLUSH),
        .inc   (ret),
        .value (head)
    );

    rcq_ptr #(.width(tag_width)) tail_ptr (
        .clk   (CLK),
        .srst  (RST),
        .clr   (FLUSH),
        .inc   (enq),
        .value (tail)
    );

    // Enqueue and retire can only target the same slot when the queue is
    // empty or full, and neither can fire in those cases, so the order of
    // the branches below only matters for a done mark racing a retire.
    for (genvar gi = 0; gi < depth; gi++) begin : g_entry
        localparam logic [tag_width-1:0] idx = tag_width'(gi);
        always_ff @(posedge CLK) begin
            if (RST || FLUSH) begin
                valid_reg[gi] <= 1'b0;
                done_reg[gi]  <= 1'b0;
            end else if (enq && tail == idx) begin
                valid_reg[gi] <= 1'b1;
                done_reg[gi]  <= 1'b0;
            end else if (ret && head == idx) begin
                valid_reg[gi] <= 1'b0;
                done_reg[gi]  <= 1'b0;
            end else if (done_hit && DONE_TAG == idx) begin
                done_reg[gi]  <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (enq) begin
            name_mem[tail] <= ENQ_NAME;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            free_e_reg    <= 1'b0;
            free_name_reg <= '0;
        end else begin
            free_e_reg <= ret;
            if (ret) begin
                free_name_reg <= name_mem[head];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + (tag_width+1)'(enq) - (tag_width+1)'(ret);
        end
    end

    assign ENQ_TAG   = tail;
    assign COUNT     = count_reg;
    assign EMPTY     = (count_reg == '0);
    assign FREE_E    = free_e_reg;
    assign FREE_NAME = free_name_reg;

`ifdef RENAME_COMMIT_STATS_EN
    logic [31:0] retire_count_reg;
    logic [31:0] stall_count_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            retire_count_reg <= '0;
            stall_count_reg  <= '0;
        end else begin
            if (ret) begin
                retire_count_reg <= retire_count_reg + 32'd1;
            end
            if (ENQ_E && !ENQ_READY) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end
        end
    end

    assign RETIRE_COUNT = retire_count_reg;
    assign STALL_COUNT  = stall_count_reg;
`endif

endmodule

// File: tb/tb_rename_commit_queue.sv
module tb_rename_commit_queue;

    logic       CLK;
    logic       RST;
    logic       ENQ_E;
    logic [5:0] ENQ_NAME;
    logic       ENQ_READY;
    logic [1:0] ENQ_TAG;
    logic       DONE_E;
    logic [1:0] DONE_TAG;
    logic       FLUSH;
    logic       FREE_E;
    logic [5:0] FREE_NAME;
    logic [2:0] COUNT;
    logic       EMPTY;
`ifdef RENAME_COMMIT_STATS_EN
    logic [31:0] RETIRE_COUNT;
    logic [31:0] STALL_COUNT;
`endif

    int checks;
    int failures;

    rename_commit_queue #(
        .name_width (6),
        .depth      (4),
        .tag_width  (2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ENQ_E     (ENQ_E),
        .ENQ_NAME  (ENQ_NAME),
        .ENQ_READY (ENQ_READY),
        .ENQ_TAG   (ENQ_TAG),
        .DONE_E    (DONE_E),
        .DONE_TAG  (DONE_TAG),
        .FLUSH     (FLUSH),
        .FREE_E    (FREE_E),
        .FREE_NAME (FREE_NAME),
        .COUNT     (COUNT),
        .EMPTY     (EMPTY)
`ifdef RENAME_COMMIT_STATS_EN
        ,
        .RETIRE_COUNT (RETIRE_COUNT),
        .STALL_COUNT  (STALL_COUNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ENQ_E = 0; ENQ_NAME = '0; DONE_E = 0; DONE_TAG = '0; FLUSH = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1;
        step();
        step();
        RST = 0;
    endtask

    task automatic enq(input logic [5:0] name, input logic [1:0] tag);
        ENQ_E = 1; ENQ_NAME = name;
        checks++;
        if (ENQ_TAG !== tag) begin
            failures++;
            $display("FAIL enq_tag name=%0d got=%0d want=%0d", name, ENQ_TAG, tag);
        end
        step();
        ENQ_E = 0;
        $display("enq name=%0d tag=%0d count=%0d", name, tag, COUNT);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (ENQ_READY !== 1'b1 || EMPTY !== 1'b1 || COUNT !== 3'd0 ||
                FREE_E !== 1'b0 || ENQ_TAG !== 2'd0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got rdy=%b empty=%b count=%0d free=%b tag=%0d want 1 1 0 0 0",
                         i, ENQ_READY, EMPTY, COUNT, FREE_E, ENQ_TAG);
            end
            step();
        end
        $display("test_reset done");
    endtask

    task automatic test_in_order();
        logic [5:0] exp_names [3];
        exp_names[0] = 6'd5; exp_names[1] = 6'd9; exp_names[2] = 6'd12;
        enq(6'd5, 2'd0);
        enq(6'd9, 2'd1);
        enq(6'd12, 2'd2);
        checks++;
        if (COUNT !== 3'd3) begin
            failures++;
            $display("FAIL inorder_count got=%0d want=3", COUNT);
        end
        // Tag 2 done first: must not retire out of order.
        DONE_E = 1; DONE_TAG = 2'd2;
        step();
        DONE_E = 0;
        step();
        checks++;
        if (FREE_E !== 1'b0) begin
            failures++;
            $display("FAIL inorder_no_early_free got=%b want=0", FREE_E);
        end
        DONE_E = 1; DONE_TAG = 2'd0;
        step();
        checks++;
        if (FREE_E !== 1'b0) begin
            failures++;
            $display("FAIL inorder_latency got=%b want=0", FREE_E);
        end
        DONE_E = 1; DONE_TAG = 2'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            DONE_E = 0;
            checks++;
            if (FREE_E !== 1'b1 || FREE_NAME !== exp_names[i]) begin
                failures++;
                $display("FAIL inorder_free idx=%0d got e=%b name=%0d want e=1 name=%0d",
                         i, FREE_E, FREE_NAME, exp_names[i]);
            end
            $display("free name=%0d", FREE_NAME);
        end
        step();
        checks++;
        if (FREE_E !== 1'b0 || FREE_NAME !== 6'd12 || EMPTY !== 1'b1) begin
            failures++;
            $display("FAIL inorder_drain got e=%b name=%0d empty=%b want e=0 name=12 empty=1",
                     FREE_E, FREE_NAME, EMPTY);
        end
    endtask

    task automatic test_full();
        do_reset();
        enq(6'd20, 2'd0);
        enq(6'd21, 2'd1);
        enq(6'd22, 2'd2);
        enq(6'd23, 2'd3);
        checks++;
        if (ENQ_READY !== 1'b0 || COUNT !== 3'd4 || ENQ_TAG !== 2'd0) begin
            failures++;
            $display("FAIL full_state got rdy=%b count=%0d tag=%0d want 0 4 0", ENQ_READY, COUNT, ENQ_TAG);
        end
        ENQ_E = 1; ENQ_NAME = 6'd24;
        step();
        ENQ_E = 0;
        checks++;
        if (COUNT !== 3'd4 || ENQ_TAG !== 2'd0) begin
            failures++;
            $display("FAIL full_ignore got count=%0d tag=%0d want 4 0", COUNT, ENQ_TAG);
        end
`ifdef RENAME_COMMIT_STATS_EN
        checks++;
        if (STALL_COUNT !== 32'd1) begin
            failures++;
            $display("FAIL stall_count1 got=%0d want=1", STALL_COUNT);
        end
`endif
        DONE_E = 1; DONE_TAG = 2'd0;
        step();
        DONE_E = 0;
        checks++;
        if (FREE_E !== 1'b0) begin
            failures++;
            $display("FAIL full_latency1 got=%b want=0", FREE_E);
        end
        step();
        checks++;
        if (FREE_E !== 1'b1 || FREE_NAME !== 6'd20 || COUNT !== 3'd3 ||
            ENQ_READY !== 1'b1 || ENQ_TAG !== 2'd0) begin
            failures++;
            $display("FAIL full_retire got e=%b name=%0d count=%0d rdy=%b tag=%0d want 1 20 3 1 0",
                     FREE_E, FREE_NAME, COUNT, ENQ_READY, ENQ_TAG);
        end
        $display("free name=%0d", FREE_NAME);
        enq(6'd25, 2'd0);
        checks++;
        if (COUNT !== 3'd4) begin
            failures++;
            $display("FAIL full_refill got=%0d want=4", COUNT);
        end
    endtask

    task automatic test_full_simul();
        // Queue full, head is tag 1 (name 21).
        DONE_E = 1; DONE_TAG = 2'd1;
        step();
        DONE_E = 0;
        ENQ_E = 1; ENQ_NAME = 6'd26;
        step();
        checks++;
        if (FREE_E !== 1'b1 || FREE_NAME !== 6'd21 || COUNT !== 3'd3 || ENQ_TAG !== 2'd1) begin
            failures++;
            $display("FAIL simul_retire got e=%b name=%0d count=%0d tag=%0d want 1 21 3 1",
                     FREE_E, FREE_NAME, COUNT, ENQ_TAG);
        end
        step();
        ENQ_E = 0;
        checks++;
        if (FREE_E !== 1'b0 || COUNT !== 3'd4 || ENQ_TAG !== 2'd2) begin
            failures++;
            $display("FAIL simul_enq got e=%b count=%0d tag=%0d want 0 4 2", FREE_E, COUNT, ENQ_TAG);
        end
`ifdef RENAME_COMMIT_STATS_EN
        checks++;
        if (RETIRE_COUNT !== 32'd2 || STALL_COUNT !== 32'd2) begin
            failures++;
            $display("FAIL stats got ret=%0d stall=%0d want 2 2", RETIRE_COUNT, STALL_COUNT);
        end
`endif
        $display("test_full_simul done count=%0d", COUNT);
    endtask

    task automatic test_flush();
        do_reset();
        enq(6'd30, 2'd0);
        enq(6'd31, 2'd1);
        enq(6'd32, 2'd2);
        DONE_E = 1; DONE_TAG = 2'd1;
        step();
        DONE_TAG = 2'd2;
        step();
        DONE_E = 0;
        // Head (tag 0) made done in the same cycle as the flush: flush wins.
        DONE_E = 1; DONE_TAG = 2'd0; FLUSH = 1;
        step();
        DONE_E = 0; FLUSH = 0;
        checks++;
        if (COUNT !== 3'd0 || EMPTY !== 1'b1 || FREE_E !== 1'b0 || ENQ_TAG !== 2'd0) begin
            failures++;
            $display("FAIL flush_state got count=%0d empty=%b free=%b tag=%0d want 0 1 0 0",
                     COUNT, EMPTY, FREE_E, ENQ_TAG);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (FREE_E !== 1'b0) begin
                failures++;
                $display("FAIL flush_no_free cyc=%0d got=%b want=0", i, FREE_E);
            end
        end
        enq(6'd33, 2'd0);
        checks++;
        if (COUNT !== 3'd1) begin
            failures++;
            $display("FAIL flush_enq_count got=%0d want=1", COUNT);
        end
        // Completion aimed at the slot enqueued the same cycle is dropped.
        DONE_E = 1; DONE_TAG = 2'd1;
        enq(6'd34, 2'd1);
        DONE_TAG = 2'd0;
        step();
        DONE_E = 0;
        step();
        checks++;
        if (FREE_E !== 1'b1 || FREE_NAME !== 6'd33) begin
            failures++;
            $display("FAIL flush_retire got e=%b name=%0d want 1 33", FREE_E, FREE_NAME);
        end
        step();
        checks++;
        if (FREE_E !== 1'b0 || COUNT !== 3'd1) begin
            failures++;
            $display("FAIL same_cycle_done got e=%b count=%0d want 0 1", FREE_E, COUNT);
        end
    endtask

    task automatic test_reset_mid();
        // Head is tag 1 (name 34), not done yet.
        DONE_E = 1; DONE_TAG = 2'd1;
        step();
        DONE_E = 0;
        RST = 1;
        step();
        RST = 0;
        checks++;
        if (FREE_E !== 1'b0 || FREE_NAME !== 6'd0 || COUNT !== 3'd0 || EMPTY !== 1'b1 ||
            ENQ_READY !== 1'b1 || ENQ_TAG !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid got e=%b name=%0d count=%0d empty=%b rdy=%b tag=%0d want 0 0 0 1 1 0",
                     FREE_E, FREE_NAME, COUNT, EMPTY, ENQ_READY, ENQ_TAG);
        end
`ifdef RENAME_COMMIT_STATS_EN
        checks++;
        if (RETIRE_COUNT !== 32'd0 || STALL_COUNT !== 32'd0) begin
            failures++;
            $display("FAIL reset_stats got ret=%0d stall=%0d want 0 0", RETIRE_COUNT, STALL_COUNT);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (FREE_E !== 1'b0) begin
                failures++;
                $display("FAIL reset_no_free cyc=%0d got=%b want=0", i, FREE_E);
            end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        idle_inputs();
        RST = 1;
        test_reset();
        test_in_order();
        test_full();
        test_full_simul();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
